// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared definitions for the pipeline flush/stall controller: stage indices,
// exception entry address, flush masks and the redirect FSM encoding.
package pipe_flush_ctrl_pkg;

  localparam int NSTAGE = 5;

  // Stage index constants; bit i of every per-stage vector is stage i.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // General exception entry address.
  localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;

  // An event flushes IF..MEM; WB keeps the committing instruction.
  localparam logic [NSTAGE-1:0] FLUSH_EVENT = 5'b01111;
  // While a redirect is pending only fetch garbage is killed.
  localparam logic [NSTAGE-1:0] FLUSH_IF    = 5'b00001;

  // Redirect FSM: IDLE = no redirect held, PEND = redirect waiting on icache.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Bundle of stall requests, commit events and stall/flush/redirect outputs
// exchanged between the pipeline stages and the flush controller.
//
// Handshake semantics: there is no valid/ready pair here. exc_req_i and
// eret_i are single-cycle commit pulses that the controller always accepts
// in the cycle they are high; stall requests are level signals sampled
// combinationally every cycle; all outputs are valid in the same cycle.
interface pipe_flush_ctrl_if;
  import pipe_flush_ctrl_pkg::*;

  logic              id_stallreq_i;
  logic              ex_stallreq_i;
  logic              mem_stallreq_i;
  logic              icache_stall_i;
  logic              exc_req_i;
  logic              eret_i;
  logic [31:0]       epc_i;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic              pc_flush_o;
  logic [31:0]       flush_pc_o;
  logic              redirect_pend_o;

  // Pipeline/core side: raises requests and events, consumes controls.
  modport master (
    output id_stallreq_i, ex_stallreq_i, mem_stallreq_i, icache_stall_i,
    output exc_req_i, eret_i, epc_i,
    input  stall_o, flush_o, pc_flush_o, flush_pc_o, redirect_pend_o
  );

  // Controller side.
  modport slave (
    input  id_stallreq_i, ex_stallreq_i, mem_stallreq_i, icache_stall_i,
    input  exc_req_i, eret_i, epc_i,
    output stall_o, flush_o, pc_flush_o, flush_pc_o, redirect_pend_o
  );

endinterface

// File: rtl/pipe_flush_ctrl_dffre.sv
// DFFRE register primitive: D flip-flop with asynchronous active-low reset
// and a synchronous load enable.
module pipe_flush_ctrl_dffre #(
  parameter int          W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Central pipeline controller: merges stall requests into a per-stage stall
// vector, turns MEM-stage exception/ERET commits into flushes plus a fetch
// redirect, and holds one pending redirect while the icache is busy.
// The FSM state is visible externally as redirect_pend_o.
module pipe_flush_ctrl
  import pipe_flush_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  pipe_flush_ctrl_if.slave bus
);

  state_t            state;
  logic [NSTAGE-1:0] req;
  logic [NSTAGE-1:0] stall_raw;
  logic              ev;
  logic              capture;
  logic [31:0]       target;
  logic [31:0]       target_q;
  logic [NSTAGE-1:0] flush_c;
  logic [NSTAGE-1:0] stall_c;
  logic              pc_flush_c;
  logic [31:0]       flush_pc_c;
  logic              force_if;

  // Map each requester onto the stage it lives in; WB never requests.
  always_comb begin
    req          = '0;
    req[STG_IF]  = bus.icache_stall_i;
    req[STG_ID]  = bus.id_stallreq_i;
    req[STG_EX]  = bus.ex_stallreq_i;
    req[STG_MEM] = bus.mem_stallreq_i;
    req[STG_WB]  = 1'b0;
  end

  // A stage holds when it or any later stage requests a stall.
  for (genvar g = 0; g < NSTAGE; g++) begin : g_stall_merge
    assign stall_raw[g] = |req[NSTAGE-1:g];
  end

  // Event decode: exception wins over ERET when both commit together.
  assign ev      = bus.exc_req_i | bus.eret_i;
  assign target  = bus.exc_req_i ? EXC_VECTOR : bus.epc_i;
  // Any event that cannot redirect right now (icache busy) is stored;
  // a later event simply overwrites the earlier one.
  assign capture = ev & bus.icache_stall_i;

  pipe_flush_ctrl_dffre #(.W(32), .RST_VAL(32'h0)) u_target_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (capture),
    .d     (target),
    .q     (target_q)
  );

  // Redirect FSM: park in PEND while the icache is busy, leave once free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (ev && bus.icache_stall_i) state <= PEND;
        PEND:    if (!bus.icache_stall_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Same-cycle flush/redirect decode from the current state and inputs.
  always_comb begin
    flush_c    = '0;
    pc_flush_c = 1'b0;
    flush_pc_c = '0;
    force_if   = 1'b0;
    case (state)
      IDLE: begin
        if (ev) begin
          flush_c    = FLUSH_EVENT;
          pc_flush_c = !bus.icache_stall_i;
          flush_pc_c = target;
        end
      end
      PEND: begin
        flush_c    = ev ? FLUSH_EVENT : FLUSH_IF;
        force_if   = 1'b1;
        pc_flush_c = !bus.icache_stall_i;
        // A fresh event on the release cycle is newer than the stored one.
        flush_pc_c = (ev && !bus.icache_stall_i) ? target : target_q;
      end
      default: begin
        flush_c = '0;
      end
    endcase
    // Flush beats stall; while pending, fetch is additionally held.
    stall_c         = stall_raw & ~flush_c;
    stall_c[STG_IF] = stall_c[STG_IF] | force_if;
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    bus.stall_o         = rst_n ? stall_c : '0;
    bus.flush_o         = rst_n ? flush_c : '0;
    bus.pc_flush_o      = rst_n & pc_flush_c;
    bus.flush_pc_o      = rst_n ? flush_pc_c : 32'h0;
    bus.redirect_pend_o = rst_n & (state == PEND);
  end

endmodule
